gpu_frame_scheduler: RTL and testbench



---
 rtl/gpu_sched_pkg.sv | 51 +++++
 rtl/gpu_frame_scheduler_if.sv | 57 +++++
 rtl/gpu_frame_mux.sv | 22 ++
 rtl/gpu_frame_scheduler.sv | 169 ++++++++++++++++
 tb/tb_gpu_frame_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_sched_pkg.sv
// gpu_sched_pkg
// Shared definitions for the GPU frame scheduler: image geometry, header word
// offsets, the scheduler state type and small address/decode helpers.
// Optional build macro used by the scheduler: SCHED_PERF_CNT_EN.
package gpu_sched_pkg;

   localparam int WORD_W      = 16;
   localparam int MEM_WORDS   = 1024;
   localparam int FRAME_WORDS = 16;
   localparam int SLOT_FRAMES = 4;
   localparam int NUM_SLOTS   = MEM_WORDS / (FRAME_WORDS * SLOT_FRAMES);

   localparam int MEM_AW      = $clog2(MEM_WORDS);
   localparam int SLOT_W      = $clog2(NUM_SLOTS);
   localparam int FRAME_IDX_W = $clog2(SLOT_FRAMES);
   localparam int WORD_IDX_W  = $clog2(FRAME_WORDS);
   localparam int FRAME_BITS  = FRAME_WORDS * WORD_W;
   localparam int MAX_EXTRA   = SLOT_FRAMES - 1;

   // Header word offsets inside frame 0 of every slot. The dependency word is
   // not interpreted by the scheduler; it only travels inside the frame data.
   localparam int HDR_CNT  = 0;
   localparam int HDR_MASK = 1;
   localparam int HDR_DEP  = 2;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      SEND,
      DONE
   } sched_state_e;

   typedef logic [MEM_WORDS-1:0][WORD_W-1:0] image_t;

   // Flat word address of word 'word' in frame 'frame' of slot 'slot'.
   function automatic logic [MEM_AW-1:0] word_addr(input logic [SLOT_W-1:0]      slot,
                                                  input logic [FRAME_IDX_W-1:0] frame,
                                                  input logic [WORD_IDX_W-1:0]  word);
      return {slot, frame, word};
   endfunction

   // Number of extra frames a slot sends after its header frame, saturated so
   // that a slot never runs past its own four frames.
   function automatic logic [FRAME_IDX_W-1:0] clamp_extra(input logic [WORD_W-1:0] cnt_word);
      if (cnt_word > WORD_W'(MAX_EXTRA)) begin
         return FRAME_IDX_W'(MAX_EXTRA);
      end
      return cnt_word[FRAME_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/gpu_frame_scheduler_if.sv
// gpu_frame_scheduler_if
// Core-side frame bus between the scheduler (master) and the core array
// (slave). The core accepts the offered frame by raising core_read_f while
// frame_being_sent is high.
//   core_read_f       core -> sched  accept current frame
//   frame_being_sent  sched -> core  frame_data valid
//   frame_data        sched -> core  16 words, word 0 in bits [15:0]
//   frame_core_mask   sched -> core  target core mask of current slot
//   frame_slot        sched -> core  slot index
//   frame_idx         sched -> core  frame index within slot
//   frame_last        sched -> core  last frame of the slot
//   sched_done        sched -> core  every slot dispatched
//   frames_sent_cnt   sched -> core  handshake count (only with SCHED_PERF_CNT_EN)
interface gpu_frame_scheduler_if;
   import gpu_sched_pkg::*;

   logic                   core_read_f;
   logic                   frame_being_sent;
   logic [FRAME_BITS-1:0]  frame_data;
   logic [WORD_W-1:0]      frame_core_mask;
   logic [SLOT_W-1:0]      frame_slot;
   logic [FRAME_IDX_W-1:0] frame_idx;
   logic                   frame_last;
   logic                   sched_done;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0]            frames_sent_cnt;
`endif

   modport master (
      input  core_read_f,
      output frame_being_sent,
      output frame_data,
      output frame_core_mask,
      output frame_slot,
      output frame_idx,
      output frame_last,
      output sched_done
`ifdef SCHED_PERF_CNT_EN
      , output frames_sent_cnt
`endif
   );

   modport slave (
      output core_read_f,
      input  frame_being_sent,
      input  frame_data,
      input  frame_core_mask,
      input  frame_slot,
      input  frame_idx,
      input  frame_last,
      input  sched_done
`ifdef SCHED_PERF_CNT_EN
      , input frames_sent_cnt
`endif
   );

endinterface

// File: rtl/gpu_frame_mux.sv
// gpu_frame_mux
// Combinational selection of one 16-word frame out of the flat program image.
//   data_frames_in  program image, element i = word i
//   slot            slot index
//   frame           frame index within the slot
//   frame_data      selected frame, word 0 in bits [15:0]
module gpu_frame_mux
   import gpu_sched_pkg::*;
(
   input  image_t                 data_frames_in,
   input  logic [SLOT_W-1:0]      slot,
   input  logic [FRAME_IDX_W-1:0] frame,
   output logic [FRAME_BITS-1:0]  frame_data
);

   // A frame is a contiguous run of words starting at {slot, frame, 0}; the
   // lowest-indexed word lands in the lowest bits of the packed slice.
   always_comb begin
      frame_data = data_frames_in[word_addr(slot, frame, '0) +: FRAME_WORDS];
   end

endmodule

// File: rtl/gpu_frame_scheduler.sv
// gpu_frame_scheduler
// Walks the 16 task slots of a preloaded program image and streams each
// non-empty slot's frames to the core array, one frame per handshake.
// The image is read in place, so it must stay stable from the fall of
// prog_loading until sched_done.
//   clk             system clock, rising edge
//   reset           asynchronous, active-high
//   prog_loading    host is loading the image; forces IDLE
//   data_frames_in  program image
//   core_if         core-side frame bus (master modport)
// Build macro SCHED_PERF_CNT_EN adds the frames_sent_cnt handshake counter.
module gpu_frame_scheduler
   import gpu_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  prog_loading,
   input  image_t                data_frames_in,
   gpu_frame_scheduler_if.master core_if
);

   sched_state_e           state_q, state_d;
   logic [SLOT_W-1:0]      slot_q, slot_d;
   logic [FRAME_IDX_W-1:0] frame_q, frame_d;
   logic [FRAME_IDX_W-1:0] extra_q, extra_d;
   logic [WORD_W-1:0]      mask_q, mask_d;
   logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;

   logic [WORD_W-1:0]      hdr_cnt_word;
   logic [WORD_W-1:0]      hdr_mask_word;
   logic                   slot_empty;
   logic                   last_slot;
   logic                   handshake;

   // Frame data is registered alongside the state, so the mux is addressed
   // with the next slot/frame and the register always matches slot_q/frame_q.
   gpu_frame_mux u_frame_mux (
      .data_frames_in (data_frames_in),
      .slot           (slot_d),
      .frame          (frame_d),
      .frame_data     (frame_data_d)
   );

   // Header words of the slot currently addressed; only meaningful in HEADER,
   // where the frame counter is always zero.
   always_comb begin
      hdr_cnt_word  = data_frames_in[word_addr(slot_q, '0, WORD_IDX_W'(HDR_CNT))];
      hdr_mask_word = data_frames_in[word_addr(slot_q, '0, WORD_IDX_W'(HDR_MASK))];
      slot_empty    = (hdr_cnt_word == '0) && (hdr_mask_word == '0);
      last_slot     = (slot_q == SLOT_W'(NUM_SLOTS - 1));
      handshake     = (state_q == SEND) && core_if.core_read_f;
   end

   // Next-state logic. prog_loading overrides everything and parks the
   // scheduler in IDLE with cleared counters. The last slot never advances
   // the slot counter; it hands over to the terminal DONE state instead.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      frame_d = frame_q;
      extra_d = extra_q;
      mask_d  = mask_q;

      if (prog_loading) begin
         state_d = IDLE;
         slot_d  = '0;
         frame_d = '0;
         extra_d = '0;
         mask_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = HEADER;
               slot_d  = '0;
               frame_d = '0;
            end
            HEADER: begin
               if (slot_empty) begin
                  if (last_slot) begin
                     state_d = DONE;
                  end else begin
                     slot_d = slot_q + 1'b1;
                  end
               end else begin
                  extra_d = clamp_extra(hdr_cnt_word);
                  mask_d  = hdr_mask_word;
                  frame_d = '0;
                  state_d = SEND;
               end
            end
            SEND: begin
               if (handshake) begin
                  if (frame_q < extra_q) begin
                     frame_d = frame_q + 1'b1;
                  end else begin
                     frame_d = '0;
                     if (last_slot) begin
                        state_d = DONE;
                     end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = HEADER;
                     end
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
               slot_d  = '0;
               frame_d = '0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         frame_q      <= '0;
         extra_q      <= '0;
         mask_q       <= '0;
         frame_data_q <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         frame_q      <= frame_d;
         extra_q      <= extra_d;
         mask_q       <= mask_d;
         frame_data_q <= frame_data_d;
      end
   end

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of accepted frames since the last IDLE entry.
   always_comb begin
      cnt_d = cnt_q;
      if (prog_loading) begin
         cnt_d = '0;
      end else if (handshake && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign core_if.frames_sent_cnt = cnt_q;
`endif

   assign core_if.frame_being_sent = (state_q == SEND);
   assign core_if.frame_data       = frame_data_q;
   assign core_if.frame_core_mask  = mask_q;
   assign core_if.frame_slot       = slot_q;
   assign core_if.frame_idx        = frame_q;
   assign core_if.frame_last       = (state_q == SEND) && (frame_q == extra_q);
   assign core_if.sched_done       = (state_q == DONE);

endmodule

// File: tb/tb_gpu_frame_scheduler.sv
// tb_gpu_frame_scheduler
// Scoreboard bench for gpu_frame_scheduler: each dispatch run derives the
// list of frames the image should produce, and a negedge monitor pops and
// compares one entry for every accepted frame.
module tb_gpu_frame_scheduler;
   import gpu_sched_pkg::*;

   logic   clk = 1'b0;
   logic   reset;
   logic   prog_loading;
   image_t img;

   gpu_frame_scheduler_if sif();

   gpu_frame_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .prog_loading   (prog_loading),
      .data_frames_in (img),
      .core_if        (sif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   slot;
      logic [1:0]   idx;
      logic         last;
      logic [15:0]  mask;
      logic [255:0] data;
   } exp_frame_t;

   exp_frame_t exp_q[$];
   int checks    = 0;
   int errors    = 0;
   int stall_cnt = 0;

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [255:0] model_frame(input int s, input int f);
      logic [255:0] d;
      for (int w = 0; w < 16; w++) d[w*16 +: 16] = img[s*64 + f*16 + w];
      return d;
   endfunction

   function automatic bit model_empty(input int s);
      return (img[s*64] == 16'h0) && (img[s*64 + 1] == 16'h0);
   endfunction

   // Reference: every non-empty slot in order sends min(word0,3)+1 frames.
   function automatic int build_expected();
      int total;
      total = 0;
      for (int s = 0; s < 16; s++) begin
         int n;
         if (model_empty(s)) continue;
         n = (img[s*64] > 16'd3) ? 3 : int'(img[s*64]);
         for (int f = 0; f <= n; f++) begin
            exp_frame_t e;
            e.slot = 4'(s);
            e.idx  = 2'(f);
            e.last = (f == n);
            e.mask = img[s*64 + 1];
            e.data = model_frame(s, f);
            exp_q.push_back(e);
            total++;
         end
      end
      return total;
   endfunction

   function automatic int lead_empty();
      int k;
      k = 0;
      while (k < 16 && model_empty(k)) k++;
      return k;
   endfunction

   task automatic randomImage();
      for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
      for (int s = 0; s < 16; s++) begin
         case ($urandom_range(0, 3))
            0: begin img[s*64] = 16'h0; img[s*64 + 1] = 16'h0; end
            1: img[s*64] = 16'($urandom_range(0, 3));
            2: img[s*64] = 16'($urandom_range(4, 65535));
            default: begin img[s*64] = 16'h0; img[s*64 + 1] = 16'($urandom_range(1, 65535)); end
         endcase
      end
   endtask

   // Monitor: one scoreboard entry per accepted frame; offered-but-refused
   // cycles are counted as stalls for the run-length check.
   always @(negedge clk) begin
      if (reset === 1'b0 && sif.frame_being_sent === 1'b1) begin
         if (sif.core_read_f === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_frame: actual slot=%0d idx=%0d required=no frame", sif.frame_slot, sif.frame_idx);
            end else begin
               exp_frame_t e;
               e = exp_q.pop_front();
               checkOutput("frame_slot", 256'(sif.frame_slot), 256'(e.slot));
               checkOutput("frame_idx", 256'(sif.frame_idx), 256'(e.idx));
               checkOutput("frame_last", 256'(sif.frame_last), 256'(e.last));
               checkOutput("frame_core_mask", 256'(sif.frame_core_mask), 256'(e.mask));
               checkOutput("frame_data", sif.frame_data, e.data);
            end
         end else begin
            stall_cnt++;
         end
      end
   end

   // One full dispatch of the current image: drop prog_loading, drive ready
   // with the given acceptance percentage, optionally hold off slot 0 frame 1
   // for three cycles, then check completion timing and return to IDLE.
   task automatic applyStimulus(input int ready_pct, input bit directed_stall);
      int frames;
      int edges;
      int stalls_left;
      int first_valid;
      int lead;
      logic [255:0] held_data;
      exp_q.delete();
      frames      = build_expected();
      lead        = lead_empty();
      held_data   = model_frame(0, 1);
      stall_cnt   = 0;
      stalls_left = directed_stall ? 3 : 0;
      first_valid = -1;
      edges       = 0;
      @(posedge clk); #1;
      prog_loading     = 1'b0;
      sif.core_read_f  = ($urandom_range(0, 99) < ready_pct);
      while (sif.sched_done !== 1'b1 && edges < 2000) begin
         @(posedge clk); #1;
         edges++;
         if (sif.frame_being_sent === 1'b1 && first_valid < 0) first_valid = edges;
         if (stalls_left > 0 && sif.frame_being_sent === 1'b1 && sif.frame_slot == 4'd0 && sif.frame_idx == 2'd1) begin
            sif.core_read_f = 1'b0;
            stalls_left--;
            checkOutput("stall_frame_idx", 256'(sif.frame_idx), 256'd1);
            checkOutput("stall_frame_data", sif.frame_data, held_data);
         end else begin
            sif.core_read_f = ($urandom_range(0, 99) < ready_pct);
         end
      end
      if (frames > 0) checkOutput("first_valid_edge", 256'(first_valid), 256'(2 + lead));
      checkOutput("run_edges", 256'(edges), 256'(1 + NUM_SLOTS + frames + stall_cnt));
      checkOutput("sched_done", 256'(sif.sched_done), 256'd1);
      checkOutput("valid_in_done", 256'(sif.frame_being_sent), 256'd0);
      checkOutput("frames_left", 256'(exp_q.size()), 256'd0);
`ifdef SCHED_PERF_CNT_EN
      checkOutput("frames_sent_cnt", 256'(sif.frames_sent_cnt), 256'(frames));
`endif
      prog_loading    = 1'b1;
      sif.core_read_f = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_sched_done", 256'(sif.sched_done), 256'd0);
      checkOutput("idle_frame_slot", 256'(sif.frame_slot), 256'd0);
      checkOutput("idle_valid", 256'(sif.frame_being_sent), 256'd0);
   endtask

   // Abort in slot 0 frame 2, then restart the same image from the top.
   task automatic applyAbort();
      int frames;
      int edges;
      randomImage();
      img[0] = 16'h0003;
      img[1] = 16'h00F0;
      exp_q.delete();
      frames = build_expected();
      @(posedge clk); #1;
      prog_loading    = 1'b0;
      sif.core_read_f = 1'b1;
      edges = 0;
      while (!(sif.frame_being_sent === 1'b1 && sif.frame_slot == 4'd0 && sif.frame_idx == 2'd2) && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("abort_reach_edge", 256'(edges), 256'd4);
      prog_loading = 1'b1;
      @(posedge clk); #1;
      sif.core_read_f = 1'b0;
      checkOutput("abort_valid", 256'(sif.frame_being_sent), 256'd0);
      checkOutput("abort_slot", 256'(sif.frame_slot), 256'd0);
      checkOutput("abort_idx", 256'(sif.frame_idx), 256'd0);
      checkOutput("abort_done", 256'(sif.sched_done), 256'd0);
`ifdef SCHED_PERF_CNT_EN
      checkOutput("abort_cnt", 256'(sif.frames_sent_cnt), 256'd0);
`endif
      if (frames < 4) $display("[TB] note: abort image has %0d frames", frames);
      applyStimulus(70, 1'b0);
   endtask

   // Main sequence: reset, directed slot 0/1/2 image with backpressure,
   // abort/restart, then randomized images.
   initial begin
      reset           = 1'b1;
      prog_loading    = 1'b1;
      sif.core_read_f = 1'b0;
      img             = '0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rst_valid", 256'(sif.frame_being_sent), 256'd0);
      checkOutput("rst_done", 256'(sif.sched_done), 256'd0);
      checkOutput("rst_last", 256'(sif.frame_last), 256'd0);
      checkOutput("rst_slot", 256'(sif.frame_slot), 256'd0);
      checkOutput("rst_idx", 256'(sif.frame_idx), 256'd0);
      checkOutput("rst_mask", 256'(sif.frame_core_mask), 256'd0);
      checkOutput("rst_data", sif.frame_data, 256'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("load_valid", 256'(sif.frame_being_sent), 256'd0);
      checkOutput("load_done", 256'(sif.sched_done), 256'd0);
      checkOutput("load_slot", 256'(sif.frame_slot), 256'd0);

      randomImage();
      for (int s = 0; s < 16; s++) begin
         img[s*64]     = 16'h0;
         img[s*64 + 1] = 16'h0;
      end
      img[0]   = 16'h0003;
      img[1]   = 16'h000F;
      img[2]   = 16'h000F;
      img[128] = 16'h0007;
      img[129] = 16'h0001;
      applyStimulus(100, 1'b1);

      applyAbort();

      for (int r = 0; r < 4; r++) begin
         randomImage();
         applyStimulus((r == 0) ? 100 : 55 + 10 * r, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
